// File: rtl/wb_register_file_pkg.sv
// wb_register_file_pkg: core-wide widths and types shared by the pipeline registers and write-back stage.
package wb_register_file_pkg;
   localparam int DATA_W    = 8;
   localparam int REG_NUM_W = 3;
   localparam int NUM_REGS  = 2 ** REG_NUM_W;
   typedef logic [REG_NUM_W-1:0] reg_num_t;
   typedef logic [DATA_W-1:0]    data_t;
endpackage

// File: rtl/wb_rf_read_port.sv
// wb_rf_read_port: one register-file read port with same-cycle write bypass.
// With WB_REG0_ZERO_EN defined, index 0 always reads 0 and never bypasses.
module wb_rf_read_port #(
   parameter int DATA_W    = wb_register_file_pkg::DATA_W,
   parameter int REG_NUM_W = wb_register_file_pkg::REG_NUM_W,
   parameter int NUM_REGS  = wb_register_file_pkg::NUM_REGS
) (
   input  logic [REG_NUM_W-1:0]       rd_num_i,
   input  logic [NUM_REGS*DATA_W-1:0] regs_i,
   input  logic                       wr_en_i,
   input  logic [REG_NUM_W-1:0]       wr_num_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   output logic [DATA_W-1:0]          rd_data_o
);
   import wb_register_file_pkg::*;
   logic              bypass;
   logic [DATA_W-1:0] stored;
   always_comb begin
      stored = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rd_num_i == REG_NUM_W'(i)) stored = regs_i[i*DATA_W +: DATA_W];
   end
   assign bypass = wr_en_i && (wr_num_i == rd_num_i);
`ifdef WB_REG0_ZERO_EN
   assign rd_data_o = (rd_num_i == '0) ? '0 : bypass ? wr_data_i : stored;
`else
   assign rd_data_o = bypass ? wr_data_i : stored;
`endif
endmodule

// File: rtl/wb_register_file.sv
// wb_register_file: write-back stage register file, two bypassed read ports, saturating commit counter.
// Defining WB_REG0_ZERO_EN hardwires register 0 to zero and drops (and does not count) writes to it.
module wb_register_file #(
   parameter int DATA_W    = wb_register_file_pkg::DATA_W,
   parameter int REG_NUM_W = wb_register_file_pkg::REG_NUM_W,
   parameter int NUM_REGS  = wb_register_file_pkg::NUM_REGS,
   parameter int CNT_W     = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 EX_WB_RegWrite,
   input  logic [DATA_W-1:0]    EX_WB_Write_Data,
   input  logic [REG_NUM_W-1:0] EX_WB_Write_Reg_Num,
   input  logic [REG_NUM_W-1:0] Read_Reg_Num_1,
   input  logic [REG_NUM_W-1:0] Read_Reg_Num_2,
   output logic [DATA_W-1:0]    Read_Data_1,
   output logic [DATA_W-1:0]    Read_Data_2,
   output logic [CNT_W-1:0]     Wr_Commit_Count
);
   import wb_register_file_pkg::*;
   logic [DATA_W-1:0]          regs_q [NUM_REGS];
   logic [DATA_W-1:0]          regs_d [NUM_REGS];
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [NUM_REGS*DATA_W-1:0] regs_flat;
   logic                       wr_en;
`ifdef WB_REG0_ZERO_EN
   assign wr_en = EX_WB_RegWrite && (EX_WB_Write_Reg_Num != '0);
`else
   assign wr_en = EX_WB_RegWrite;
`endif
   // if rather than a ternary so an X index leaves unaddressed registers untouched
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++)
         if (wr_en && EX_WB_Write_Reg_Num == REG_NUM_W'(i)) regs_d[i] = EX_WB_Write_Data;
      cnt_d = (wr_en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         regs_q <= '{default: '0};
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end
   wb_rf_read_port #(.DATA_W(DATA_W), .REG_NUM_W(REG_NUM_W), .NUM_REGS(NUM_REGS)) u_rd1 (
      .rd_num_i  (Read_Reg_Num_1),
      .regs_i    (regs_flat),
      .wr_en_i   (EX_WB_RegWrite),
      .wr_num_i  (EX_WB_Write_Reg_Num),
      .wr_data_i (EX_WB_Write_Data),
      .rd_data_o (Read_Data_1)
   );
   wb_rf_read_port #(.DATA_W(DATA_W), .REG_NUM_W(REG_NUM_W), .NUM_REGS(NUM_REGS)) u_rd2 (
      .rd_num_i  (Read_Reg_Num_2),
      .regs_i    (regs_flat),
      .wr_en_i   (EX_WB_RegWrite),
      .wr_num_i  (EX_WB_Write_Reg_Num),
      .wr_data_i (EX_WB_Write_Data),
      .rd_data_o (Read_Data_2)
   );
   assign Wr_Commit_Count = cnt_q;
endmodule
